// File: rtl/ps2_key_event_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ps2_key_event_queue_if                                           |
// | Purpose : byte-in / event-out bus between PS2_Controller, decoder and CPU  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface ps2_key_event_queue_if #(
  parameter int AW = 4
) ();
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [6:0]  query;
  logic        is_pressed;
  logic [18:0] evt_data;
  logic        evt_valid;
  logic        evt_ready;
  logic [AW:0] count;
  logic        overflow;
  logic        clear;

  modport master (
    output rx_data, rx_valid, query, evt_ready, clear,
    input  is_pressed, evt_data, evt_valid, count, overflow
  );

  modport slave (
    input  rx_data, rx_valid, query, evt_ready, clear,
    output is_pressed, evt_data, evt_valid, count, overflow
  );
endinterface
`default_nettype wire

// File: rtl/ps2_key_event_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ps2_key_event_queue                                              |
// | Purpose : PS/2 set-2 decoder with key bitmap and first-word-fall-through   |
// |           event FIFO; the default keymap is a built-in table.             |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ps2_key_event_queue #(
  parameter int         AW            = 4,
  parameter bit         FILTER_REPEAT = 1'b0,
  parameter logic [6:0] PAUSE_CODE    = 7'h10
) (
  input wire logic             CLOCK_50,
  input wire logic             reset,
  ps2_key_event_queue_if.slave bus
);

  localparam int          c_DEPTH    = 1 << AW;
  localparam logic [AW:0] c_PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [2:0]  c_SKIP_LEN = 3'd7;
  localparam logic [2:0]  c_SKIP_ONE = 3'd1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_PAUSE   = 3'd4
  } state_t;

  // Index is {extended, scan byte}; 0 means unmapped.
  function automatic logic [6:0] f_keymap(input logic [8:0] idx);
    f_keymap = 7'h00;
    case (idx)
      9'h012: f_keymap = 7'h29;  9'h059: f_keymap = 7'h2A;
      9'h014: f_keymap = 7'h2B;  9'h011: f_keymap = 7'h2D;
      9'h058: f_keymap = 7'h28;  9'h077: f_keymap = 7'h17;
      9'h01C: f_keymap = 7'h4E;  9'h032: f_keymap = 7'h4F;
      9'h021: f_keymap = 7'h50;  9'h023: f_keymap = 7'h51;
      9'h024: f_keymap = 7'h52;  9'h02B: f_keymap = 7'h53;
      9'h034: f_keymap = 7'h54;  9'h033: f_keymap = 7'h55;
      9'h043: f_keymap = 7'h56;  9'h03B: f_keymap = 7'h57;
      9'h042: f_keymap = 7'h58;  9'h04B: f_keymap = 7'h59;
      9'h03A: f_keymap = 7'h5A;  9'h031: f_keymap = 7'h5B;
      9'h044: f_keymap = 7'h5C;  9'h04D: f_keymap = 7'h5D;
      9'h015: f_keymap = 7'h5E;  9'h02D: f_keymap = 7'h5F;
      9'h01B: f_keymap = 7'h60;  9'h02C: f_keymap = 7'h61;
      9'h03C: f_keymap = 7'h62;  9'h02A: f_keymap = 7'h63;
      9'h01D: f_keymap = 7'h68;  9'h022: f_keymap = 7'h69;
      9'h035: f_keymap = 7'h6A;  9'h01A: f_keymap = 7'h6B;
      9'h016: f_keymap = 7'h01;  9'h01E: f_keymap = 7'h02;
      9'h026: f_keymap = 7'h03;  9'h025: f_keymap = 7'h04;
      9'h02E: f_keymap = 7'h05;  9'h036: f_keymap = 7'h06;
      9'h03D: f_keymap = 7'h07;  9'h03E: f_keymap = 7'h08;
      9'h046: f_keymap = 7'h09;  9'h045: f_keymap = 7'h0A;
      9'h029: f_keymap = 7'h0B;  9'h05A: f_keymap = 7'h0C;
      9'h066: f_keymap = 7'h0D;  9'h00D: f_keymap = 7'h0E;
      9'h076: f_keymap = 7'h0F;  9'h005: f_keymap = 7'h11;
      9'h006: f_keymap = 7'h12;  9'h004: f_keymap = 7'h13;
      9'h00C: f_keymap = 7'h14;  9'h070: f_keymap = 7'h1E;
      9'h069: f_keymap = 7'h1F;  9'h072: f_keymap = 7'h20;
      9'h07A: f_keymap = 7'h21;  9'h06B: f_keymap = 7'h22;
      9'h073: f_keymap = 7'h23;  9'h075: f_keymap = 7'h24;
      9'h074: f_keymap = 7'h25;
      9'h114: f_keymap = 7'h2C;  9'h111: f_keymap = 7'h2E;
      9'h11F: f_keymap = 7'h2F;  9'h127: f_keymap = 7'h30;
      9'h175: f_keymap = 7'h64;  9'h172: f_keymap = 7'h65;
      9'h16B: f_keymap = 7'h66;  9'h174: f_keymap = 7'h67;
      9'h15A: f_keymap = 7'h26;  9'h14A: f_keymap = 7'h27;
      default: f_keymap = 7'h00;
    endcase
  endfunction

  state_t       r_state, w_state_next;
  logic [2:0]   r_skip, w_skip_next;
  logic         w_lookup_go, w_lookup_ext, w_lookup_brk, w_pause_go;
  logic [6:0]   w_lookup_code;

  logic         r_req_valid, r_req_brk, r_req_pause;
  logic [6:0]   r_req_code;

  logic [127:0] r_bitmap, w_bitmap_next;
  logic         w_evt_repeat, w_push_req;
  logic [9:0]   w_mods;
  logic [18:0]  w_evt_word;

  logic [18:0]  r_mem [c_DEPTH];
  logic [AW:0]  r_wr_ptr, r_rd_ptr;
  logic         r_overflow;
  logic         w_empty, w_full, w_pop, w_push;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_skip  <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_skip  <= w_skip_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_skip_next  = r_skip;
    w_lookup_go  = 1'b0;
    w_lookup_ext = 1'b0;
    w_lookup_brk = 1'b0;
    w_pause_go   = 1'b0;
    if (bus.rx_valid) begin
      unique case (r_state)
        S_IDLE: begin
          case (bus.rx_data)
            8'hE0: w_state_next = S_EXT;
            8'hF0: w_state_next = S_BRK;
            8'hE1: begin
              w_state_next = S_PAUSE;
              w_skip_next  = c_SKIP_LEN;
            end
            8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF: ;  // BAT, ack, resend, error
            default: w_lookup_go = 1'b1;
          endcase
        end
        S_EXT: begin
          w_state_next = S_IDLE;
          if (bus.rx_data == 8'hF0) begin
            w_state_next = S_EXT_BRK;
          end else if (bus.rx_data != 8'h12 && bus.rx_data != 8'h59) begin
            w_lookup_go  = 1'b1;
            w_lookup_ext = 1'b1;
          end
        end
        S_BRK: begin
          w_state_next = S_IDLE;
          w_lookup_go  = 1'b1;
          w_lookup_brk = 1'b1;
        end
        S_EXT_BRK: begin
          w_state_next = S_IDLE;
          w_lookup_go  = 1'b1;
          w_lookup_ext = 1'b1;
          w_lookup_brk = 1'b1;
        end
        S_PAUSE: begin
          w_skip_next = r_skip - c_SKIP_ONE;
          if (r_skip == c_SKIP_ONE) begin
            w_pause_go   = 1'b1;
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  assign w_lookup_code = f_keymap({w_lookup_ext, bus.rx_data});

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_req_valid <= 1'b0;
      r_req_brk   <= 1'b0;
      r_req_pause <= 1'b0;
      r_req_code  <= 7'h00;
    end else begin
      r_req_valid <= (w_lookup_go && w_lookup_code != 7'h00) || w_pause_go;
      r_req_brk   <= w_lookup_brk && !w_pause_go;
      r_req_pause <= w_pause_go;
      r_req_code  <= w_pause_go ? PAUSE_CODE : w_lookup_code;
    end
  end

  // Pause is reported as a make but never latched as held.
  always_comb begin
    w_bitmap_next = r_bitmap;
    if (r_req_valid && !r_req_pause && r_req_code != 7'h00) begin
      w_bitmap_next[r_req_code] = !r_req_brk;
    end
  end

  assign w_evt_repeat = !r_req_brk && !r_req_pause && r_bitmap[r_req_code];
  assign w_mods = {w_bitmap_next[7'h29], w_bitmap_next[7'h2A], w_bitmap_next[7'h2B],
                   w_bitmap_next[7'h2C], w_bitmap_next[7'h2D], w_bitmap_next[7'h2E],
                   w_bitmap_next[7'h2F], w_bitmap_next[7'h30], w_bitmap_next[7'h28],
                   w_bitmap_next[7'h17]};
  assign w_evt_word = {r_req_brk, w_evt_repeat, w_mods, r_req_code};
  assign w_push_req = r_req_valid && !(FILTER_REPEAT && w_evt_repeat);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_bitmap <= '0;
    end else begin
      r_bitmap <= w_bitmap_next;
    end
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && bus.evt_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = w_push_req && (!w_full || w_pop);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else if (bus.clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      if (w_push_req && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_push && !bus.clear) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_evt_word;
    end
  end

  assign bus.evt_valid  = !w_empty;
  assign bus.evt_data   = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign bus.count      = r_wr_ptr - r_rd_ptr;
  assign bus.overflow   = r_overflow;
  assign bus.is_pressed = r_bitmap[bus.query];

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_queue.sv
`default_nettype none
// Randomised and directed bench for ps2_key_event_queue against a byte-level
// behavioural model (keymap table, held-key set, bounded event queue).
module tb_ps2_key_event_queue;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int NK    = 69;
  // {ext, scan byte, keycode}
  localparam int unsigned KEYS [NK] = '{
    32'h00_12_29, 32'h00_59_2A, 32'h00_14_2B, 32'h00_11_2D, 32'h00_58_28, 32'h00_77_17,
    32'h00_1C_4E, 32'h00_32_4F, 32'h00_21_50, 32'h00_23_51, 32'h00_24_52, 32'h00_2B_53,
    32'h00_34_54, 32'h00_33_55, 32'h00_43_56, 32'h00_3B_57, 32'h00_42_58, 32'h00_4B_59,
    32'h00_3A_5A, 32'h00_31_5B, 32'h00_44_5C, 32'h00_4D_5D, 32'h00_15_5E, 32'h00_2D_5F,
    32'h00_1B_60, 32'h00_2C_61, 32'h00_3C_62, 32'h00_2A_63, 32'h00_1D_68, 32'h00_22_69,
    32'h00_35_6A, 32'h00_1A_6B, 32'h00_16_01, 32'h00_1E_02, 32'h00_26_03, 32'h00_25_04,
    32'h00_2E_05, 32'h00_36_06, 32'h00_3D_07, 32'h00_3E_08, 32'h00_46_09, 32'h00_45_0A,
    32'h00_29_0B, 32'h00_5A_0C, 32'h00_66_0D, 32'h00_0D_0E, 32'h00_76_0F, 32'h00_05_11,
    32'h00_06_12, 32'h00_04_13, 32'h00_0C_14, 32'h00_70_1E, 32'h00_69_1F, 32'h00_72_20,
    32'h00_7A_21, 32'h00_6B_22, 32'h00_73_23, 32'h00_75_24, 32'h00_74_25,
    32'h01_14_2C, 32'h01_11_2E, 32'h01_1F_2F, 32'h01_27_30, 32'h01_75_64, 32'h01_72_65,
    32'h01_6B_66, 32'h01_74_67, 32'h01_5A_26, 32'h01_4A_27};
  localparam logic [7:0] NOISE [7] = '{8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF, 8'h01, 8'hF9};

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [6:0] query;
  logic       clear;
  logic       ready_m;

  ps2_key_event_queue_if #(.AW(AW)) bm ();
  ps2_key_event_queue_if #(.AW(3))  bf ();

  assign bm.rx_data = rx_data;  assign bf.rx_data = rx_data;
  assign bm.rx_valid = rx_valid; assign bf.rx_valid = rx_valid;
  assign bm.query = query;      assign bf.query = query;
  assign bm.clear = clear;      assign bf.clear = clear;
  assign bm.evt_ready = ready_m;
  assign bf.evt_ready = 1'b1;

  ps2_key_event_queue #(.AW(AW), .FILTER_REPEAT(1'b0), .PAUSE_CODE(7'h10)) dut (
    .CLOCK_50(clk), .reset(reset), .bus(bm));
  ps2_key_event_queue #(.AW(3), .FILTER_REPEAT(1'b1), .PAUSE_CODE(7'h10)) dut_f (
    .CLOCK_50(clk), .reset(reset), .bus(bf));

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          km [int];
  bit          mbm [128];
  logic [18:0] exp_q [$];
  bit          m_ovf, m_ext, m_brk;
  int          m_pause;
  logic [18:0] f_log [$];

  always @(negedge clk) if (bf.evt_valid) f_log.push_back(bf.evt_data);

  task automatic model_reset();
    foreach (mbm[i]) mbm[i] = 1'b0;
    exp_q.delete();
    m_ovf = 0; m_ext = 0; m_brk = 0; m_pause = 0;
  endtask

  task automatic model_event(input bit brk, input int code, input bit pause);
    bit rep;
    logic [9:0] mods;
    rep = (!brk && !pause) ? mbm[code] : 1'b0;
    if (!pause) mbm[code] = !brk;
    mods = {mbm['h29], mbm['h2A], mbm['h2B], mbm['h2C], mbm['h2D],
            mbm['h2E], mbm['h2F], mbm['h30], mbm['h28], mbm['h17]};
    if (exp_q.size() < DEPTH) exp_q.push_back({brk, rep, mods, 7'(code)});
    else m_ovf = 1;
  endtask

  task automatic model_key(input bit ext, input bit brk, input logic [7:0] b);
    int k;
    k = ext * 256 + int'(b);
    if (km.exists(k)) model_event(brk, km[k], 1'b0);
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) model_event(1'b0, 'h10, 1'b1);
    end else if (m_ext || m_brk) begin
      if (m_ext && !m_brk && b == 8'hF0) m_brk = 1;
      else begin
        if (m_brk || (b != 8'h12 && b != 8'h59)) model_key(m_ext, m_brk, b);
        m_ext = 0; m_brk = 0;
      end
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE1) m_pause = 7;
    else if (!(b inside {8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF})) model_key(1'b0, 1'b0, b);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    model_byte(b);
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic pop_one();
    ready_m = 1'b1; tick(1); ready_m = 1'b0;
  endtask

  task automatic test_reset();
    tick(3);
    reset = 1'b0;
    n_vec++; if (bm.count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bm.count); end
    n_vec++; if (bm.evt_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bm.evt_valid); end
    n_vec++; if (bm.evt_data !== 19'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", bm.evt_data); end
    n_vec++; if (bm.overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bm.overflow); end
    query = 7'h4E; #1;
    n_vec++; if (bm.is_pressed !== 1'b0) begin n_err++; $display("FAIL reset_pressed: got %b want 0", bm.is_pressed); end
  endtask

  task automatic test_shift_a();
    logic [18:0] e1, e2;
    e1 = {2'b00, 10'h200, 7'h29};
    e2 = {2'b00, 10'h200, 7'h4E};
    send_byte(8'h12);
    n_vec++; if (bm.evt_valid !== 1'b0) begin n_err++; $display("FAIL latency_early: got %b want 0", bm.evt_valid); end
    tick(1);
    n_vec++; if (bm.evt_valid !== 1'b1) begin n_err++; $display("FAIL latency_due: got %b want 1", bm.evt_valid); end
    send_byte(8'h1C); tick(2);
    n_vec++; if (bm.count !== 3'd2) begin n_err++; $display("FAIL shift_a_count: got %0d want 2", bm.count); end
    n_vec++; if (bm.evt_data !== e1) begin n_err++; $display("FAIL shift_evt: got %h want %h", bm.evt_data, e1); end
    void'(exp_q.pop_front()); pop_one();
    n_vec++; if (bm.evt_data !== e2) begin n_err++; $display("FAIL a_evt: got %h want %h", bm.evt_data, e2); end
    void'(exp_q.pop_front()); pop_one();
    query = 7'h4E; #1;
    n_vec++; if (bm.is_pressed !== 1'b1) begin n_err++; $display("FAIL a_pressed: got %b want 1", bm.is_pressed); end
  endtask

  task automatic test_ext_break();
    logic [18:0] e_make, e_brk;
    e_make = {2'b00, 10'h000, 7'h64};
    e_brk  = {2'b10, 10'h000, 7'h64};
    send_byte(8'hF0); send_byte(8'h12); send_byte(8'hF0); send_byte(8'h1C); tick(2);
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
      n_vec++; if (bm.evt_data !== exp_q[0]) begin n_err++; $display("FAIL release_drain: got %h want %h", bm.evt_data, exp_q[0]); end
      void'(exp_q.pop_front()); pop_one();
    end
    send_byte(8'hE0); send_byte(8'h75); tick(2);
    n_vec++; if (bm.evt_data !== e_make) begin n_err++; $display("FAIL ext_make: got %h want %h", bm.evt_data, e_make); end
    void'(exp_q.pop_front()); pop_one();
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75); tick(2);
    n_vec++; if (bm.evt_data !== e_brk) begin n_err++; $display("FAIL ext_break: got %h want %h", bm.evt_data, e_brk); end
    void'(exp_q.pop_front()); pop_one();
    query = 7'h64; #1;
    n_vec++; if (bm.is_pressed !== 1'b0) begin n_err++; $display("FAIL ext_released: got %b want 0", bm.is_pressed); end
  endtask

  task automatic test_repeat();
    bit exp_rep [3] = '{1'b0, 1'b1, 1'b1};
    logic [18:0] f_want;
    f_want = {2'b00, 10'h000, 7'h4E};
    f_log.delete();
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C); tick(3);
    n_vec++; if (bm.count !== 3'd3) begin n_err++; $display("FAIL repeat_count: got %0d want 3", bm.count); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (bm.evt_data[17] !== exp_rep[i]) begin n_err++; $display("FAIL repeat_bit%0d: got %b want %b", i, bm.evt_data[17], exp_rep[i]); end
      n_vec++; if (bm.evt_data !== exp_q[0]) begin n_err++; $display("FAIL repeat_evt%0d: got %h want %h", i, bm.evt_data, exp_q[0]); end
      void'(exp_q.pop_front()); pop_one();
    end
    n_vec++; if (f_log.size() != 1) begin n_err++; $display("FAIL filter_count: got %0d want 1", f_log.size()); end
    if (f_log.size() > 0) begin
      n_vec++; if (f_log[0] !== f_want) begin n_err++; $display("FAIL filter_evt: got %h want %h", f_log[0], f_want); end
    end
    send_byte(8'hF0); send_byte(8'h1C); tick(2);
    n_vec++; if (bm.evt_data !== exp_q[0]) begin n_err++; $display("FAIL repeat_release: got %h want %h", bm.evt_data, exp_q[0]); end
    void'(exp_q.pop_front()); pop_one();
  endtask

  task automatic test_overflow();
    logic [7:0] keys [5] = '{8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
    foreach (keys[i]) send_byte(keys[i]);
    tick(2);
    n_vec++; if (bm.count !== 3'd4) begin n_err++; $display("FAIL ovf_count: got %0d want 4", bm.count); end
    n_vec++; if (bm.overflow !== 1'b1 || !m_ovf) begin n_err++; $display("FAIL ovf_flag: got %b want 1", bm.overflow); end
    n_vec++; if (bm.evt_data !== exp_q[0] || bm.evt_data[6:0] !== 7'h4F) begin n_err++; $display("FAIL ovf_head: got %h want %h", bm.evt_data, exp_q[0]); end
    clear = 1'b1; tick(1); clear = 1'b0;
    exp_q.delete(); m_ovf = 0;
    n_vec++; if (bm.count !== 3'd0) begin n_err++; $display("FAIL clear_count: got %0d want 0", bm.count); end
    n_vec++; if (bm.overflow !== 1'b0) begin n_err++; $display("FAIL clear_ovf: got %b want 0", bm.overflow); end
    n_vec++; if (bm.evt_valid !== 1'b0) begin n_err++; $display("FAIL clear_valid: got %b want 0", bm.evt_valid); end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    foreach (seq[i]) send_byte(seq[i]);
    tick(2);
    n_vec++; if (bm.count !== 3'd1) begin n_err++; $display("FAIL pause_count: got %0d want 1", bm.count); end
    n_vec++; if (bm.evt_data[6:0] !== 7'h10 || bm.evt_data[18:17] !== 2'b00) begin n_err++; $display("FAIL pause_code: got %h want make of 10", bm.evt_data); end
    n_vec++; if (bm.evt_data !== exp_q[0]) begin n_err++; $display("FAIL pause_evt: got %h want %h", bm.evt_data, exp_q[0]); end
    query = 7'h10; #1;
    n_vec++; if (bm.is_pressed !== 1'b0) begin n_err++; $display("FAIL pause_bitmap: got %b want 0", bm.is_pressed); end
    void'(exp_q.pop_front()); pop_one();
    send_byte(8'h1C); tick(2);
    n_vec++; if (bm.evt_data !== exp_q[0] || bm.evt_data[6:0] !== 7'h4E) begin n_err++; $display("FAIL after_pause: got %h want %h", bm.evt_data, exp_q[0]); end
    void'(exp_q.pop_front()); pop_one();
  endtask

  task automatic test_same_cycle();
    logic [7:0] keys [4] = '{8'h34, 8'h33, 8'h43, 8'h3B};
    logic [18:0] head;
    foreach (keys[i]) send_byte(keys[i]);
    tick(2);
    n_vec++; if (bm.count !== 3'd4) begin n_err++; $display("FAIL fill_count: got %0d want 4", bm.count); end
    head = exp_q.pop_front();
    n_vec++; if (bm.evt_data !== head) begin n_err++; $display("FAIL fill_head: got %h want %h", bm.evt_data, head); end
    rx_data = 8'h42; rx_valid = 1'b1; model_byte(8'h42);
    tick(1);
    rx_valid = 1'b0; ready_m = 1'b1;
    tick(1);
    ready_m = 1'b0;
    n_vec++; if (bm.count !== 3'd4) begin n_err++; $display("FAIL pushpop_count: got %0d want 4", bm.count); end
    n_vec++; if (bm.overflow !== 1'b0) begin n_err++; $display("FAIL pushpop_ovf: got %b want 0", bm.overflow); end
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
      n_vec++; if (bm.evt_data !== exp_q[0]) begin n_err++; $display("FAIL pushpop_drain: got %h want %h", bm.evt_data, exp_q[0]); end
      void'(exp_q.pop_front()); pop_one();
    end
  endtask

  task automatic test_reset_mid();
    logic [18:0] want;
    want = {2'b00, 10'h000, 7'h24};
    send_byte(8'hE0);
    reset = 1'b1; model_reset(); tick(1); reset = 1'b0;
    n_vec++; if (bm.count !== 3'd0) begin n_err++; $display("FAIL midreset_count: got %0d want 0", bm.count); end
    send_byte(8'h75); tick(2);
    n_vec++; if (bm.evt_data !== want) begin n_err++; $display("FAIL midreset_ext: got %h want %h", bm.evt_data, want); end
    void'(exp_q.pop_front()); pop_one();
    send_byte(8'hE1); send_byte(8'h14);
    reset = 1'b1; model_reset(); tick(1); reset = 1'b0;
    send_byte(8'h1C); tick(2);
    n_vec++; if (bm.evt_data !== exp_q[0] || bm.evt_data[6:0] !== 7'h4E) begin n_err++; $display("FAIL midreset_pause: got %h want %h", bm.evt_data, exp_q[0]); end
    void'(exp_q.pop_front()); pop_one();
  endtask

  task automatic test_random();
    int unsigned e;
    int kind, q;
    for (int it = 0; it < 30; it++) begin
      for (int a = 0; a < $urandom_range(1, 6); a++) begin
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
          send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
          send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        end else if (kind == 1) begin
          send_byte(NOISE[$urandom_range(0, 6)]);
        end else if (kind == 2) begin
          send_byte(8'hE0);
          if ($urandom_range(0, 1) == 1) send_byte(8'hF0);
          send_byte($urandom_range(0, 1) == 1 ? 8'h12 : 8'h59);
        end else begin
          e = KEYS[$urandom_range(0, NK - 1)];
          if (e[16]) send_byte(8'hE0);
          if ($urandom_range(0, 9) < 4) send_byte(8'hF0);
          send_byte(e[15:8]);
        end
        if ($urandom_range(0, 1) == 1) tick(1);
      end
      tick(2);
      n_vec++; if (bm.count !== 3'(exp_q.size())) begin n_err++; $display("FAIL rnd_count%0d: got %0d want %0d", it, bm.count, exp_q.size()); end
      n_vec++; if (bm.overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf%0d: got %b want %b", it, bm.overflow, m_ovf); end
      e = KEYS[$urandom_range(0, NK - 1)];
      q = int'(e[6:0]);
      query = 7'(q); #1;
      n_vec++; if (bm.is_pressed !== mbm[q]) begin n_err++; $display("FAIL rnd_pressed%0d: code %h got %b want %b", it, q, bm.is_pressed, mbm[q]); end
      for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
        n_vec++; if (bm.evt_data !== exp_q[0]) begin n_err++; $display("FAIL rnd_evt%0d: got %h want %h", it, bm.evt_data, exp_q[0]); end
        void'(exp_q.pop_front()); pop_one();
      end
      n_vec++; if (bm.evt_valid !== 1'b0) begin n_err++; $display("FAIL rnd_empty%0d: got %b want 0", it, bm.evt_valid); end
      if (m_ovf) begin
        clear = 1'b1; tick(1); clear = 1'b0; m_ovf = 0;
      end
    end
  endtask

  initial begin
    int unsigned e;
    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; query = 7'h00; clear = 1'b0; ready_m = 1'b0;
    model_reset();
    for (int i = 0; i < NK; i++) begin
      e = KEYS[i];
      km[int'(e[23:16]) * 256 + int'(e[15:8])] = int'(e[7:0]);
    end
    test_reset();
    test_shift_a();
    test_ext_break();
    test_repeat();
    test_overflow();
    test_pause();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
